piso_serializer: RTL

Parallel-in serial-out serializer with valid/ready handshakes on both sides. It accepts a WIDTH-bit parallel word, holds it in an internal register, and shifts it out one bit per accepted serial beat, flagging the final bit. It is the transmit end of a parallel register stage: words that a parallel register would hold are streamed onto a one-bit link for a downstream deserializer.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_bit_counter.sv | 40 ++++
 rtl/piso_serializer.sv | 88 ++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer: FSM state
// encoding and the bit-counter width helper.
package piso_pkg;

    // Two-state FSM encoded as plain constants so older tools see a simple vector.
    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter that tracks which bit of the current word is on the serial link.
// It clears on a new load or on the final-bit transfer and saturates at
// WIDTH-1, so it never leaves the 0..WIDTH-1 range.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_VAL = {CNT_W{1'b0}};

    logic [CNT_W-1:0] r_count;
    logic             w_term;

    assign w_term = (r_count == TERM_VAL);
    assign o_term = w_term;

    // Count accepted bits; clear takes priority, and the count stops at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= ZERO_VAL;
        end else if (i_clr) begin
            r_count <= ZERO_VAL;
        end else if (i_en && !w_term) begin
            r_count <= r_count + ONE_VAL;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer. Accepts a WIDTH-bit word over a
// valid/ready handshake and streams it one bit per accepted beat, flagging the
// final bit. A new word can be accepted in the final-bit cycle, so words
// stream back to back with no idle cycle between them.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             last,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic             w_busy;
    logic             w_term;
    logic             w_last;
    logic             w_out_fire;
    logic             w_d_ready;
    logic             w_load;
    logic             w_cnt_clr;

    // Decode handshake qualifiers from the registered state and counter.
    always_comb begin
        w_busy     = (r_state == ST_SHIFT);
        w_last     = w_busy && w_term;
        w_out_fire = w_busy && sout_ready;
        // Ready in IDLE, or in the final-bit cycle when downstream takes that bit.
        w_d_ready  = !rst && (!w_busy || (w_last && sout_ready));
        w_load     = d_valid && w_d_ready;
        w_cnt_clr  = w_load || (w_out_fire && w_last);
    end

    // Next shift-register contents after one bit leaves; vacated bit is zero.
    always_comb begin
        w_shreg_next = r_shreg;
        if (MSB_FIRST) begin
            w_shreg_next = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
            w_shreg_next = {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    // FSM and shift register: load wins over shift so the final-bit cycle can reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= {WIDTH{1'b0}};
        end else if (w_load) begin
            r_state <= ST_SHIFT;
            r_shreg <= d;
        end else if (w_out_fire) begin
            r_state <= w_last ? ST_IDLE : ST_SHIFT;
            r_shreg <= w_shreg_next;
        end else begin
            r_state <= r_state;
            r_shreg <= r_shreg;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_out_fire),
        .o_term (w_term)
    );

    assign d_ready    = w_d_ready;
    assign sout       = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign sout_valid = w_busy;
    assign last       = w_last;
    assign busy       = w_busy;

endmodule
